// File: rtl/frame_bank_pkg.sv
// Shared definitions for the frame-buffer bank arbiter: FSM encoding,
// free-bank selection and parameter legality.
package frame_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } fsm_state_t;

  localparam int LOAD_CNT_W = 4;

  // Lowest bank index that is neither being read nor holding a pending ready frame.
  function automatic int lowest_free(input int rd, input int rdy, input logic rdy_v, input int n);
    int res;
    res = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (i != rd && !(rdy_v && i == rdy)) res = i;
    end
    return res;
  endfunction

  function automatic logic params_legal(input int n, input int bw, input int ll);
    return (n >= 2) && (n <= 4) && (bw >= 1) && ((1 << bw) >= n) && (ll >= 1) && (ll <= 15);
  endfunction

endpackage

// File: rtl/bank_sync_edge.sv
// Synchronises the asynchronous camera frame-sync level and emits a registered
// one-cycle pulse on each falling edge.
module bank_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic bank_valid,
  output logic switch_flag
);

  logic sync1, sync2, hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      hist        <= 1'b0;
      switch_flag <= 1'b0;
    end else begin
      sync1       <= bank_valid;
      sync2       <= sync1;
      hist        <= sync2;
      switch_flag <= hist & ~sync2;
    end
  end

endmodule

// File: rtl/frame_bank_arbiter.sv
// Frame-store bank arbiter: newest-frame triple buffering for 3-4 banks,
// lockstep ping-pong for 2 banks.
module frame_bank_arbiter
  import frame_bank_pkg::*;
#(
  parameter int NUM_BANKS = 3,
  parameter int BANK_W    = 2,
  parameter int LOAD_LEN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              bank_valid,
  input  logic              frame_write_done,
  input  logic              frame_read_done,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] rd_bank,
  output logic              wr_load,
  output logic              rd_load,
  output logic              frame_dropped,
  output logic              frame_repeated
);

  generate
    if (!params_legal(NUM_BANKS, BANK_W, LOAD_LEN)) begin : g_param_check
      $error("frame_bank_arbiter: illegal NUM_BANKS/BANK_W/LOAD_LEN combination");
    end
  endgenerate

  localparam logic [LOAD_CNT_W-1:0] LAST_CNT = LOAD_CNT_W'(LOAD_LEN - 1);

  logic                  switch_flag;
  fsm_state_t            wr_state, wr_state_next, rd_state, rd_state_next;
  logic [LOAD_CNT_W-1:0] wr_cnt, rd_cnt;
  logic [BANK_W-1:0]     ready_bank;
  logic                  ready_valid;

  logic [BANK_W-1:0]     wr_bank_next, rd_bank_next, ready_bank_next;
  logic                  ready_valid_next, dropped_next, repeated_next;
  logic                  do_commit, do_select;

  bank_sync_edge u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .bank_valid  (bank_valid),
    .switch_flag (switch_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= ST_IDLE;
      rd_state <= ST_IDLE;
    end else begin
      wr_state <= wr_state_next;
      rd_state <= rd_state_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      ST_IDLE:  wr_state_next = ST_LOAD;
      ST_LOAD:  if (wr_cnt == LAST_CNT) wr_state_next = ST_RUN;
      ST_RUN:   if (switch_flag && enable) wr_state_next = ST_DRAIN;
      ST_DRAIN: if (frame_write_done) wr_state_next = ST_IDLE;
      default:  wr_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      ST_IDLE:  rd_state_next = ST_LOAD;
      ST_LOAD:  if (rd_cnt == LAST_CNT) rd_state_next = ST_RUN;
      ST_RUN:   if (switch_flag && enable) rd_state_next = ST_DRAIN;
      ST_DRAIN: if (frame_read_done) rd_state_next = ST_IDLE;
      default:  rd_state_next = ST_IDLE;
    endcase
  end

  // Load pulses lag the LOAD state by one cycle so the outputs stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      wr_load <= 1'b0;
      rd_load <= 1'b0;
    end else begin
      wr_cnt  <= (wr_state == ST_LOAD) ? wr_cnt + 1'b1 : '0;
      rd_cnt  <= (rd_state == ST_LOAD) ? rd_cnt + 1'b1 : '0;
      wr_load <= (wr_state == ST_LOAD);
      rd_load <= (rd_state == ST_LOAD);
    end
  end

  assign do_commit = (wr_state == ST_DRAIN) && frame_write_done;
  assign do_select = (rd_state == ST_DRAIN) && frame_read_done;

  always_comb begin
    wr_bank_next     = wr_bank;
    rd_bank_next     = rd_bank;
    ready_bank_next  = ready_bank;
    ready_valid_next = ready_valid;
    dropped_next     = 1'b0;
    repeated_next    = 1'b0;
    if (NUM_BANKS == 2) begin
      if (do_commit) wr_bank_next = (wr_bank == '0) ? BANK_W'(1) : '0;
      if (do_select) rd_bank_next = (rd_bank == '0) ? BANK_W'(1) : '0;
    end else begin
      if (do_select) begin
        // A commit in the same cycle is forwarded straight to the reader.
        if (do_commit)        rd_bank_next = wr_bank;
        else if (ready_valid) rd_bank_next = ready_bank;
        else                  repeated_next = 1'b1;
        ready_valid_next = 1'b0;
      end
      if (do_commit) begin
        ready_bank_next = wr_bank;
        dropped_next    = ready_valid;
        if (!do_select) ready_valid_next = 1'b1;
        wr_bank_next = BANK_W'(lowest_free(int'(rd_bank_next), int'(wr_bank), !do_select, NUM_BANKS));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank        <= '0;
      rd_bank        <= BANK_W'(NUM_BANKS - 1);
      ready_bank     <= '0;
      ready_valid    <= 1'b0;
      frame_dropped  <= 1'b0;
      frame_repeated <= 1'b0;
    end else begin
      wr_bank        <= wr_bank_next;
      rd_bank        <= rd_bank_next;
      ready_bank     <= ready_bank_next;
      ready_valid    <= ready_valid_next;
      frame_dropped  <= dropped_next;
      frame_repeated <= repeated_next;
    end
  end

endmodule
